// File: rtl/dualclk_fifo_pkg.sv
// rtl/dualclk_fifo_pkg.sv - default parameters and Gray-code helpers for the dual-clock FIFO
`timescale 1ns/10ps
package dualclk_fifo_pkg;

  localparam int DEF_DATA_W      = 32;
  localparam int DEF_ADDR_W      = 8;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_AF_LEVEL    = 240;
  localparam int DEF_AE_LEVEL    = 16;

  // Helpers work on 32-bit words; callers zero-extend narrower pointers and truncate the result.
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/dc_gray_sync.sv
// rtl/dc_gray_sync.sv - multi-flop synchroniser for a Gray-coded pointer
`timescale 1ns/10ps
module dc_gray_sync #(
  parameter int WIDTH  = 9,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] sync_q [STAGES];
  logic [WIDTH-1:0] sync_d [STAGES];

  always_comb begin
    sync_d[0] = d;
    for (int i = 1; i < STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        sync_q[i] <= sync_d[i];
      end
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/dualclk_fifo.sv
// rtl/dualclk_fifo.sv - asynchronous FIFO with Gray-pointer crossing, registered flags and fill counts
`timescale 1ns/10ps
module dualclk_fifo
  import dualclk_fifo_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int AF_LEVEL    = DEF_AF_LEVEL,
  parameter int AE_LEVEL    = DEF_AE_LEVEL
) (
  input  logic              clk_wr,
  input  logic              clk_rd,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] data_in,
  output logic              full,
  output logic              almost_full,
  output logic [ADDR_W:0]   wr_count,
  output logic              overflow,
  input  logic              rd_en,
  output logic [DATA_W-1:0] data_out,
  output logic              empty,
  output logic              almost_empty,
  output logic [ADDR_W:0]   rd_count,
  output logic              underflow
);

  localparam int PTR_W = ADDR_W + 1;
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [PTR_W-1:0] AF_THR = PTR_W'(AF_LEVEL);
  localparam logic [PTR_W-1:0] AE_THR = PTR_W'(AE_LEVEL);

  // Reset asserts asynchronously everywhere but releases on each domain's own clock.
  logic [1:0] wr_rst_q, wr_rst_d;
  logic [1:0] rd_rst_q, rd_rst_d;
  logic       wr_rst_n, rd_rst_n;

  always_comb begin
    wr_rst_d = {wr_rst_q[0], 1'b1};
    rd_rst_d = {rd_rst_q[0], 1'b1};
  end

  always_ff @(posedge clk_wr or negedge rst_n) begin
    if (!rst_n) wr_rst_q <= '0;
    else        wr_rst_q <= wr_rst_d;
  end

  always_ff @(posedge clk_rd or negedge rst_n) begin
    if (!rst_n) rd_rst_q <= '0;
    else        rd_rst_q <= rd_rst_d;
  end

  assign wr_rst_n = wr_rst_q[1];
  assign rd_rst_n = rd_rst_q[1];

  logic [DATA_W-1:0] mem [DEPTH];

  // Write domain
  logic [PTR_W-1:0] wr_bin_q, wr_bin_d, wr_gray_q, wr_gray_d;
  logic [PTR_W-1:0] wr_count_q, wr_count_d;
  logic             full_q, full_d, almost_full_q, almost_full_d;
  logic             overflow_q, overflow_d;
  logic             wr_accept;
  logic [PTR_W-1:0] rd_gray_sync, rd_bin_sync;

  // Read domain
  logic [PTR_W-1:0]  rd_bin_q, rd_bin_d, rd_gray_q, rd_gray_d;
  logic [PTR_W-1:0]  rd_count_q, rd_count_d;
  logic              empty_q, empty_d, almost_empty_q, almost_empty_d;
  logic              underflow_q, underflow_d;
  logic              rd_accept;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic [PTR_W-1:0]  wr_gray_sync, wr_bin_sync;

  dc_gray_sync #(.WIDTH(PTR_W), .STAGES(SYNC_STAGES)) u_rd2wr_sync (
    .clk   (clk_wr),
    .rst_n (wr_rst_n),
    .d     (rd_gray_q),
    .q     (rd_gray_sync)
  );

  dc_gray_sync #(.WIDTH(PTR_W), .STAGES(SYNC_STAGES)) u_wr2rd_sync (
    .clk   (clk_rd),
    .rst_n (rd_rst_n),
    .d     (wr_gray_q),
    .q     (wr_gray_sync)
  );

  assign rd_bin_sync = PTR_W'(gray2bin(32'(rd_gray_sync)));
  assign wr_bin_sync = PTR_W'(gray2bin(32'(wr_gray_sync)));

  // Flags and counts look at the post-edge pointer so full asserts on the edge that fills the last slot.
  always_comb begin
    wr_accept     = wr_en && !full_q;
    wr_bin_d      = wr_bin_q + PTR_W'(wr_accept);
    wr_gray_d     = PTR_W'(bin2gray(32'(wr_bin_d)));
    full_d        = (wr_gray_d == {~rd_gray_sync[PTR_W-1 -: 2], rd_gray_sync[PTR_W-3:0]});
    wr_count_d    = wr_bin_d - rd_bin_sync;
    almost_full_d = (wr_count_d >= AF_THR);
    overflow_d    = wr_en && full_q;
  end

  always_ff @(posedge clk_wr or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      wr_bin_q      <= '0;
      wr_gray_q     <= '0;
      wr_count_q    <= '0;
      full_q        <= 1'b0;
      almost_full_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      wr_bin_q      <= wr_bin_d;
      wr_gray_q     <= wr_gray_d;
      wr_count_q    <= wr_count_d;
      full_q        <= full_d;
      almost_full_q <= almost_full_d;
      overflow_q    <= overflow_d;
    end
  end

  always_ff @(posedge clk_wr) begin
    if (wr_accept) mem[wr_bin_q[ADDR_W-1:0]] <= data_in;
  end

  always_comb begin
    rd_accept      = rd_en && !empty_q;
    rd_bin_d       = rd_bin_q + PTR_W'(rd_accept);
    rd_gray_d      = PTR_W'(bin2gray(32'(rd_bin_d)));
    empty_d        = (rd_gray_d == wr_gray_sync);
    rd_count_d     = wr_bin_sync - rd_bin_d;
    almost_empty_d = (rd_count_d <= AE_THR);
    underflow_d    = rd_en && empty_q;
    data_out_d     = rd_accept ? mem[rd_bin_q[ADDR_W-1:0]] : data_out_q;
  end

  always_ff @(posedge clk_rd or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      rd_bin_q       <= '0;
      rd_gray_q      <= '0;
      rd_count_q     <= '0;
      empty_q        <= 1'b1;
      almost_empty_q <= 1'b1;
      underflow_q    <= 1'b0;
      data_out_q     <= '0;
    end else begin
      rd_bin_q       <= rd_bin_d;
      rd_gray_q      <= rd_gray_d;
      rd_count_q     <= rd_count_d;
      empty_q        <= empty_d;
      almost_empty_q <= almost_empty_d;
      underflow_q    <= underflow_d;
      data_out_q     <= data_out_d;
    end
  end

  assign full         = full_q;
  assign almost_full  = almost_full_q;
  assign wr_count     = wr_count_q;
  assign overflow     = overflow_q;
  assign data_out     = data_out_q;
  assign empty        = empty_q;
  assign almost_empty = almost_empty_q;
  assign rd_count     = rd_count_q;
  assign underflow    = underflow_q;

endmodule

// File: tb/tb_dualclk_fifo.sv
// tb/tb_dualclk_fifo.sv - scoreboard bench for dualclk_fifo
`timescale 1ns/10ps
module tb_dualclk_fifo;

  localparam int SYNC = 2;
  localparam realtime SKEW = 0.2;

  logic        clk_wr = 1'b0;
  logic        clk_rd = 1'b0;
  logic        rst_n  = 1'b0;
  logic        wr_en  = 1'b0;
  logic [31:0] data_in = '0;
  logic        full, almost_full, overflow;
  logic [8:0]  wr_count;
  logic        rd_en = 1'b0;
  logic [31:0] data_out;
  logic        empty, almost_empty, underflow;
  logic [8:0]  rd_count;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_q [$];
  logic [31:0] last_rd = '0;
  int          excl_viol = 0;
  int          wr_sent = 0;
  int          rd_got = 0;
  int          budget = 0;
  int          lat = 0;
  logic        pend = 1'b0;

  always #5    clk_wr = ~clk_wr;
  always #13.5 clk_rd = ~clk_rd;

  dualclk_fifo dut (
    .clk_wr       (clk_wr),
    .clk_rd       (clk_rd),
    .rst_n        (rst_n),
    .wr_en        (wr_en),
    .data_in      (data_in),
    .full         (full),
    .almost_full  (almost_full),
    .wr_count     (wr_count),
    .overflow     (overflow),
    .rd_en        (rd_en),
    .data_out     (data_out),
    .empty        (empty),
    .almost_empty (almost_empty),
    .rd_count     (rd_count),
    .underflow    (underflow)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic sb_check(input string tag, input logic [31:0] got);
    logic [31:0] exp;
    if (exp_q.size() == 0) begin
      chk({tag, "_sb_underrun"}, 64'(exp_q.size()), 64'd1);
    end else begin
      exp = exp_q.pop_front();
      last_rd = exp;
      chk(tag, got, exp);
    end
  endtask

  task automatic wr_word(input logic [31:0] d);
    @(negedge clk_wr);
    wr_en   = 1'b1;
    data_in = d;
    if (!full) exp_q.push_back(d);
    @(posedge clk_wr);
    #SKEW;
    wr_en = 1'b0;
  endtask

  task automatic drain(input int n, input string tag);
    int got = 0;
    int cyc = 0;
    while (got < n && cyc < 3000) begin
      @(negedge clk_rd);
      if (!empty) begin
        rd_en = 1'b1;
        @(posedge clk_rd);
        #SKEW;
        rd_en = 1'b0;
        sb_check(tag, data_out);
        got++;
      end
      cyc++;
    end
    if (got < n) chk({tag, "_timeout"}, 64'(got), 64'(n));
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete, got %0d vectors expected completion", n_vec);
    $fatal(1);
  end

  initial begin
    // Reset state
    #40;
    chk("rst_full", full, 0);
    chk("rst_almost_full", almost_full, 0);
    chk("rst_empty", empty, 1);
    chk("rst_almost_empty", almost_empty, 1);
    chk("rst_wr_count", wr_count, 0);
    chk("rst_rd_count", rd_count, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_underflow", underflow, 0);
    chk("rst_data_out", data_out, 0);
    rst_n = 1'b1;
    repeat (5) @(posedge clk_rd);

    // Basic: 5 words in order, empty deasserts within SYNC+2 read edges of the first write
    wr_word(32'h0000_0001);
    lat = 0;
    while (lat < 10) begin
      @(posedge clk_rd);
      lat++;
      #SKEW;
      if (!empty) break;
    end
    chk("empty_deassert", empty, 0);
    chk("empty_deassert_latency_ok", lat <= SYNC + 2, 1);
    for (int i = 2; i <= 5; i++) wr_word(32'(i));
    drain(5, "basic");
    chk("basic_empty", empty, 1);
    chk("basic_rd_count", rd_count, 0);
    repeat (5) @(posedge clk_wr);

    // Fill to full with almost_full threshold
    for (int i = 1; i <= 256; i++) begin
      wr_word(32'h1000_0000 + 32'(i));
      if (i == 239) chk("af_at_239", almost_full, 0);
      if (i == 240) chk("af_at_240", almost_full, 1);
      if (i == 255) chk("full_at_255", full, 0);
    end
    chk("full_at_256", full, 1);
    chk("wr_count_256", wr_count, 256);
    wr_word(32'hDEAD_BEEF);
    chk("overflow_pulse", overflow, 1);
    chk("wr_count_after_ovf", wr_count, 256);
    @(posedge clk_wr);
    #SKEW;
    chk("overflow_clear", overflow, 0);

    // Drain with full-release latency and almost_empty threshold
    drain(1, "fill");
    lat = 0;
    while (lat < 10) begin
      @(posedge clk_wr);
      lat++;
      #SKEW;
      if (!full) break;
    end
    chk("full_deassert", full, 0);
    chk("full_deassert_latency_ok", lat <= SYNC + 2, 1);
    drain(238, "fill");
    chk("rd_count_17", rd_count, 17);
    chk("ae_at_17", almost_empty, 0);
    drain(1, "fill");
    chk("rd_count_16", rd_count, 16);
    chk("ae_at_16", almost_empty, 1);
    drain(16, "fill");
    chk("fill_empty", empty, 1);
    chk("fill_rd_count", rd_count, 0);

    // Read on empty
    @(negedge clk_rd);
    rd_en = 1'b1;
    @(posedge clk_rd);
    #SKEW;
    chk("underflow_pulse", underflow, 1);
    chk("underflow_hold", data_out, last_rd);
    @(negedge clk_rd);
    rd_en = 1'b0;
    @(posedge clk_rd);
    #SKEW;
    chk("underflow_clear", underflow, 0);
    chk("underflow_hold2", data_out, last_rd);

    // Wrap: 1000 random words through both pointer wraps
    fork
      begin
        budget = 0;
        while (wr_sent < 1000 && budget < 40000) begin
          @(negedge clk_wr);
          if (full && empty) excl_viol++;
          wr_en   = ($urandom_range(0, 3) != 0);
          data_in = $urandom;
          if (wr_en && !full) begin
            exp_q.push_back(data_in);
            wr_sent++;
          end
          budget++;
        end
        @(negedge clk_wr);
        wr_en = 1'b0;
      end
      begin
        for (int c = 0; c < 20000; c++) begin
          @(negedge clk_rd);
          if (pend) begin
            sb_check("wrap", data_out);
            rd_got++;
          end
          if (full && empty) excl_viol++;
          if (rd_got == 1000) break;
          rd_en = ($urandom_range(0, 3) != 0);
          pend  = rd_en && !empty;
        end
        rd_en = 1'b0;
      end
    join
    chk("wrap_sent", wr_sent, 1000);
    chk("wrap_received", rd_got, 1000);
    chk("wrap_full_empty_excl", excl_viol, 0);
    chk("wrap_sb_drained", exp_q.size(), 0);

    // Reset mid-operation with 100 words stored
    for (int i = 0; i < 100; i++) wr_word(32'h2000_0000 + 32'(i));
    repeat (6) @(posedge clk_rd);
    chk("pre_rst_rd_count", rd_count, 100);
    @(negedge clk_wr);
    rst_n = 1'b0;
    #20;
    chk("mid_rst_empty", empty, 1);
    chk("mid_rst_wr_count", wr_count, 0);
    rst_n = 1'b1;
    exp_q.delete();
    repeat (4) @(posedge clk_rd);
    @(negedge clk_rd);
    chk("post_rst_empty", empty, 1);
    chk("post_rst_rd_count", rd_count, 0);
    chk("post_rst_data_out", data_out, 0);
    @(negedge clk_wr);
    chk("post_rst_wr_count", wr_count, 0);
    wr_word(32'hCAFE_F00D);
    drain(1, "post_rst_first");
    chk("post_rst_final_empty", empty, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dualclk_fifo.md
DUALCLK_FIFO -- requirements
Module: dualclk_fifo

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32: width of each data word.
REQ-002 The block SHALL have parameter ADDR_W, default 8: depth is 2**ADDR_W words.
REQ-003 The block SHALL have parameter SYNC_STAGES, default 2: flop stages per pointer synchroniser; legal range 2..4.
REQ-004 The block SHALL have parameter AF_LEVEL, default 240: almost_full threshold in words.
REQ-005 The block SHALL have parameter AE_LEVEL, default 16: almost_empty threshold in words; 1 <= AE_LEVEL < AF_LEVEL <= 2**ADDR_W.
REQ-006 The block SHALL have port clk_wr, input, 1 bit: write-domain clock.
REQ-007 The block SHALL have port clk_rd, input, 1 bit: read-domain clock, asynchronous to clk_wr.
REQ-008 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low, serving both domains.
REQ-009 The block SHALL have these write-domain ports:
- wr_en, input, 1 bit: write request.
- data_in, input, DATA_W bits: write data.
- full, output, 1 bit.
- almost_full, output, 1 bit.
- wr_count, output, ADDR_W+1 bits: fill level seen by the write side.
- overflow, output, 1 bit: one-cycle pulse.
REQ-010 The block SHALL have these read-domain ports:
- rd_en, input, 1 bit: read request.
- data_out, output, DATA_W bits: read data.
- empty, output, 1 bit.
- almost_empty, output, 1 bit.
- rd_count, output, ADDR_W+1 bits: fill level seen by the read side.
- underflow, output, 1 bit: one-cycle pulse.

Function
REQ-011 A write SHALL be accepted on a clk_wr edge when wr_en=1 and full=0; data_in is stored at wr_ptr and wr_ptr increments.
REQ-012 A read SHALL be accepted on a clk_rd edge when rd_en=1 and empty=0; data_out updates on that same edge (1-cycle latency) and rd_ptr increments.
REQ-013 data_out SHALL hold its value on every clk_rd edge with no accepted read.
REQ-014 Pointers SHALL be ADDR_W+1 bits, binary internally, and cross domains only as Gray code through SYNC_STAGES flops.
REQ-015 Pointers SHALL wrap naturally at 2**(ADDR_W+1).
REQ-016 full SHALL be registered and SHALL equal 1 when the next wr_gray equals the synchronised rd_gray with its two MSBs inverted.
REQ-017 empty SHALL be registered and SHALL equal 1 when the next rd_gray equals the synchronised wr_gray.
REQ-018 wr_count SHALL equal (wr_ptr - synced rd_ptr) mod 2**(ADDR_W+1).
REQ-019 rd_count SHALL equal (synced wr_ptr - rd_ptr) mod 2**(ADDR_W+1).
REQ-020 Both counts SHALL be registered and SHALL be in the range 0..2**ADDR_W.
REQ-021 almost_full SHALL equal (wr_count >= AF_LEVEL), registered; almost_empty SHALL equal (rd_count <= AE_LEVEL), registered.
REQ-022 Flags and counts SHALL be pessimistic across the crossing:
- After the last slot is written, full SHALL assert on the accepting edge.
- full SHALL deassert within SYNC_STAGES+2 clk_wr edges of the freeing read.
- empty SHALL deassert within SYNC_STAGES+2 clk_rd edges of the first write.
REQ-023 wr_en while full=1 SHALL be ignored (no pointer or memory change), with overflow=1 for exactly that clk_wr cycle.
REQ-024 rd_en while empty=1 SHALL be ignored (data_out held), with underflow=1 for exactly that clk_rd cycle.
REQ-025 Simultaneous write and read, including at the full or empty boundary, SHALL each be evaluated only against their own domain's registered flag.
REQ-026 Word order SHALL be strictly FIFO, with no loss or duplication across pointer wrap.

Reset
REQ-027 rst_n assertion SHALL asynchronously reset both domains.
REQ-028 rst_n deassertion SHALL be synchronised separately into each domain with a 2-flop synchroniser.
REQ-029 Reset values SHALL be:
- Pointers and synchroniser flops: 0.
- full=0, almost_full=0, empty=1, almost_empty=1.
- wr_count=0, rd_count=0.
- overflow=0, underflow=0.
- data_out=0.
REQ-030 Memory contents SHALL NOT be cleared by reset; stored data is unreachable after reset.
REQ-031 rst_n asserted mid-transfer SHALL discard all stored words; after reset, the first word read SHALL be the first word written after reset.

Structure
REQ-032 Package dualclk_fifo_pkg SHALL hold the bin2gray and gray2bin functions and the default parameter constants.
REQ-033 The Gray pointer synchroniser SHALL be sub-module dc_gray_sync (parameters WIDTH, STAGES), instantiated once per direction.
REQ-034 Storage SHALL be an inferred simple dual-port array with the write port on clk_wr and the read port on clk_rd.

Verification
REQ-035 The bench SHALL cover the following directed scenarios (clk_wr 100 MHz, clk_rd 37 MHz):
- Basic: write 0x00000001..0x00000005 -> reads return the same 5 words in order; empty=1 afterwards, rd_count=0.
- Fill to full: write 256 words with rd_en=0 -> full=1 on the 256th accepting edge; a 257th wr_en -> overflow pulse and no change to stored data.
- Read on empty: rd_en=1 with empty=1 -> underflow pulse for 1 clk_rd cycle; data_out unchanged.
- Wrap: 1000 words streamed with random wr_en/rd_en -> exact order preserved; full and empty never both 1 in the same domain.
- Thresholds: fill to 240 -> almost_full=1; drain to 16 -> almost_empty=1.
- Reset mid-operation: rst_n pulsed low with 100 words stored -> empty=1, wr_count=0, data_out=0; next written word 0xCAFEF00D is the first word read.
